// File: rtl/ram_fifo_pkg.sv
// ---------------------------------------------------------------------------
// ram_fifo_pkg
//   Shared types and defaults for the RAM-backed FIFO controller.
//   - buf_state_e : occupancy of the 2-entry output skid buffer. The encoding
//                   is chosen to equal the entry count.
//   - AW_DEFAULT / DW_DEFAULT : default RAM address and data widths.
//   - buf_count() : entry count held in a given skid state.
// ---------------------------------------------------------------------------
package ram_fifo_pkg;

  localparam int AW_DEFAULT = 8;
  localparam int DW_DEFAULT = 32;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_e;

  function automatic logic [1:0] buf_count(input buf_state_e s);
    return s;
  endfunction

endpackage

// File: rtl/ram_fifo_skid.sv
// ---------------------------------------------------------------------------
// ram_fifo_skid
//   Two-entry output skid buffer that absorbs RAM read data so the read
//   pipeline never has to be stalled mid-flight. entry0 is always the head.
//
// Ports
//   clk, rst      : clock, asynchronous active-high reset
//   capture       : capture_data is valid this cycle (RAM read returning)
//   capture_data  : RAM read data
//   ready         : downstream accepts the head entry
//   valid, data   : head entry valid / value
//   count         : entries currently held (0..2)
// ---------------------------------------------------------------------------
module ram_fifo_skid
  import ram_fifo_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          capture,
  input  logic [DW-1:0] capture_data,
  input  logic          ready,
  output logic          valid,
  output logic [DW-1:0] data,
  output logic [1:0]    count
);

  buf_state_e    state, state_next;
  logic [DW-1:0] entry0, entry1;
  logic          pop;

  assign pop = valid & ready;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge value of every other register, regardless of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= BUF_EMPTY;
    else     state <= state_next;
  end

  // NOTE: state_next gets a default before the case so no path leaves it
  // unassigned; otherwise a latch would be inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      BUF_EMPTY: if (capture) state_next = BUF_ONE;
      BUF_ONE: begin
        if (capture && !pop)      state_next = BUF_TWO;
        else if (!capture && pop) state_next = BUF_EMPTY;
      end
      BUF_TWO:   if (pop && !capture) state_next = BUF_ONE;
      default:   state_next = BUF_EMPTY;
    endcase
  end

  // NOTE: the data entries are qualified by the reset state register, so they
  // carry no reset; a stale value is never observable.
  always_ff @(posedge clk) begin
    unique case (state)
      BUF_EMPTY: if (capture) entry0 <= capture_data;
      BUF_ONE: begin
        if (capture && pop) entry0 <= capture_data;
        else if (capture)   entry1 <= capture_data;
      end
      BUF_TWO: begin
        // A capture while full is only possible alongside a pop; the read
        // issue logic guarantees it.
        if (pop) begin
          entry0 <= entry1;
          if (capture) entry1 <= capture_data;
        end
      end
      default: ;
    endcase
  end

  assign valid = (state != BUF_EMPTY);
  assign data  = entry0;
  assign count = buf_count(state);

endmodule

// File: rtl/ram_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// ram_fifo_ctrl
//   FIFO controller around an external dual-port RAM with a registered read
//   port. Port A is write-only (pushes), port B is read-only (prefetch into a
//   2-entry skid buffer). Sustains one push and one pop per clock.
//
// Parameters
//   AW, DW              : RAM address / data width; depth is 2**AW
//   AFULL_TH, AEMPTY_TH : almost-full / almost-empty thresholds
//                         (only with RAM_FIFO_LEVEL_EN)
//
// Ports
//   clk, rst                    : clock, asynchronous active-high reset
//   inValid, inReady, inData    : push handshake
//   outValid, outReady, outData : pop handshake
//   level                       : RAM entries + read in flight + skid entries
//   aEn, aWrite, aAddr, aWriteData          : RAM port A (write)
//   bEn, bWrite, bAddr, bWriteData, bReadData : RAM port B (read, data valid
//                                               the cycle after the bEn edge)
//   almostFull, almostEmpty     : registered level flags
//                                 (only with RAM_FIFO_LEVEL_EN)
//
// Build option: define RAM_FIFO_LEVEL_EN to add the almost-full/empty flags.
// ---------------------------------------------------------------------------
module ram_fifo_ctrl
  import ram_fifo_pkg::*;
#(
  parameter int AW = AW_DEFAULT,
  parameter int DW = DW_DEFAULT
`ifdef RAM_FIFO_LEVEL_EN
  ,
  parameter int AFULL_TH  = (1 << AW) - 4,
  parameter int AEMPTY_TH = 4
`endif
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inValid,
  output logic          inReady,
  input  logic [DW-1:0] inData,
  output logic          outValid,
  input  logic          outReady,
  output logic [DW-1:0] outData,
  output logic [AW+1:0] level,
  output logic          aEn,
  output logic          aWrite,
  output logic [AW-1:0] aAddr,
  output logic [DW-1:0] aWriteData,
  output logic          bEn,
  output logic          bWrite,
  output logic [AW-1:0] bAddr,
  output logic [DW-1:0] bWriteData,
  input  logic [DW-1:0] bReadData
`ifdef RAM_FIFO_LEVEL_EN
  ,
  output logic          almostFull,
  output logic          almostEmpty
`endif
);

  localparam int              LW      = AW + 2;
  localparam logic [AW-1:0]   PTR_ONE = AW'(1);
  localparam logic [AW:0]     CNT_ONE = (AW + 1)'(1);

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   ram_count;
  logic          in_flight;
  logic          push, pop, rd_issue;
  logic [1:0]    skid_count;

  // Full when the MSB of the count is set (count == DEPTH). A pop does not
  // free RAM space, so it cannot raise inReady in the same cycle.
  assign inReady = !rst && !ram_count[AW];
  assign push    = inValid && inReady;
  assign pop     = outValid && outReady;

  // Issue a read only if the skid buffer can absorb it. Counting this cycle's
  // pop as free space is what keeps the read stream going at one per cycle.
  // ram_count is registered, so a word written at edge E is first read at E+1,
  // and the two ports never touch the same address in one cycle.
  assign rd_issue = (ram_count != '0)
                 && ((3'(skid_count) + 3'(in_flight)) < (3'd2 + 3'(pop)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ram_count <= '0;
      in_flight <= 1'b0;
    end else begin
      if (push)     wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_issue) rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !rd_issue)      ram_count <= ram_count + CNT_ONE;
      else if (!push && rd_issue) ram_count <= ram_count - CNT_ONE;
      // Cleared by reset, so read data returning after a reset is ignored.
      in_flight <= rd_issue;
    end
  end

  assign aEn        = push;
  assign aWrite     = push;
  assign aAddr      = wr_ptr;
  assign aWriteData = inData;

  assign bEn        = rd_issue;
  assign bWrite     = 1'b0;
  assign bAddr      = rd_ptr;
  assign bWriteData = '0;

  ram_fifo_skid #(.DW(DW)) u_skid (
    .clk          (clk),
    .rst          (rst),
    .capture      (in_flight),
    .capture_data (bReadData),
    .ready        (outReady),
    .valid        (outValid),
    .data         (outData),
    .count        (skid_count)
  );

  assign level = LW'(ram_count) + LW'(in_flight) + LW'(skid_count);

`ifdef RAM_FIFO_LEVEL_EN
  // Reads only move entries between stages, so only push/pop change the total.
  logic [AW+1:0] level_next;
  assign level_next = level + LW'(push) - LW'(pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      almostFull  <= 1'b0;
      almostEmpty <= 1'b1;
    end else begin
      almostFull  <= (level_next >= LW'(AFULL_TH));
      almostEmpty <= (level_next <= LW'(AEMPTY_TH));
    end
  end
`endif

endmodule
